// File: rtl/precomp_table_gen.sv
// Builds the 1024-entry fixed-base table i*16^j*B by driving an external point adder
// and streaming each affine (x, y, t) entry into the coordinate RAMs in address order.
module precomp_table_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic [254:0] bx,
  input  logic [254:0] by,
  input  logic [254:0] bt,
  input  logic         start_valid,
  output logic         start_ready,
  output logic         busy,
  output logic         done_valid,
  input  logic         done_ready,
  output logic         wr_en,
  output logic [9:0]   wr_addr,
  output logic [255:0] wr_x,
  output logic [255:0] wr_y,
  output logic [255:0] wr_t,
  output logic [254:0] pa_x1,
  output logic [254:0] pa_y1,
  output logic [254:0] pa_t1,
  output logic [254:0] pa_z1,
  output logic [254:0] pa_x2,
  output logic [254:0] pa_y2,
  output logic [254:0] pa_t2,
  output logic [254:0] pa_z2,
  output logic         pa_affine,
  output logic         pa_req_valid,
  input  logic         pa_req_ready,
  input  logic         pa_req_busy,
  input  logic         pa_res_valid,
  output logic         pa_res_ready,
  input  logic [254:0] pa_x3,
  input  logic [254:0] pa_y3,
  input  logic [254:0] pa_t3,
  input  logic [254:0] pa_z3
);

  typedef enum logic [2:0] {
    IDLE, WR_ZERO, WR_ONE, ADD_REQ, ADD_WAIT, WR_SUM, DONE
  } state_t;

  state_t       state;
  logic [254:0] q_x, q_y, q_t;
  logic [254:0] acc_x, acc_y, acc_t;
  logic [4:0]   i;
  logic [5:0]   j;

  // The adder always returns an affine result, so its z output carries nothing we need.
  logic unused_z3;
  assign unused_z3 = ^pa_z3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      q_x          <= '0;
      q_y          <= '0;
      q_t          <= '0;
      acc_x        <= '0;
      acc_y        <= '0;
      acc_t        <= '0;
      i            <= '0;
      j            <= '0;
      start_ready  <= 1'b0;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_x         <= '0;
      wr_y         <= '0;
      wr_t         <= '0;
      pa_x1        <= '0;
      pa_y1        <= '0;
      pa_t1        <= '0;
      pa_z1        <= '0;
      pa_x2        <= '0;
      pa_y2        <= '0;
      pa_t2        <= '0;
      pa_z2        <= '0;
      pa_affine    <= 1'b0;
      pa_req_valid <= 1'b0;
      pa_res_ready <= 1'b0;
    end else begin
      start_ready <= 1'b0;
      wr_en       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            q_x         <= bx;
            q_y         <= by;
            q_t         <= bt;
            acc_x       <= bx;
            acc_y       <= by;
            acc_t       <= bt;
            j           <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b1;
            state       <= WR_ZERO;
          end
        end
        WR_ZERO: begin
          wr_en   <= 1'b1;
          wr_addr <= {j, 4'd0};
          wr_x    <= '0;
          wr_y    <= 256'd1;
          wr_t    <= '0;
          state   <= WR_ONE;
        end
        WR_ONE: begin
          wr_en        <= 1'b1;
          wr_addr      <= {j, 4'd1};
          wr_x         <= {1'b0, q_x};
          wr_y         <= {1'b0, q_y};
          wr_t         <= {1'b0, q_t};
          acc_x        <= q_x;
          acc_y        <= q_y;
          acc_t        <= q_t;
          i            <= 5'd2;
          // First add of the row is q + q; acc is being loaded with q this same cycle.
          pa_x1        <= q_x;
          pa_y1        <= q_y;
          pa_t1        <= q_t;
          pa_z1        <= 255'd1;
          pa_x2        <= q_x;
          pa_y2        <= q_y;
          pa_t2        <= q_t;
          pa_z2        <= 255'd1;
          pa_affine    <= 1'b1;
          pa_req_valid <= 1'b1;
          pa_res_ready <= 1'b0;
          state        <= ADD_REQ;
        end
        ADD_REQ: begin
          if (pa_req_ready) begin
            pa_req_valid <= 1'b0;
            pa_affine    <= 1'b0;
            state        <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          if (pa_res_valid && !pa_req_busy) begin
            acc_x        <= pa_x3;
            acc_y        <= pa_y3;
            acc_t        <= pa_t3;
            pa_res_ready <= 1'b1;
            state        <= WR_SUM;
          end
        end
        WR_SUM: begin
          if (!i[4]) begin
            wr_en        <= 1'b1;
            wr_addr      <= {j, i[3:0]};
            wr_x         <= {1'b0, acc_x};
            wr_y         <= {1'b0, acc_y};
            wr_t         <= {1'b0, acc_t};
            i            <= i + 5'd1;
            pa_x1        <= acc_x;
            pa_y1        <= acc_y;
            pa_t1        <= acc_t;
            pa_z1        <= 255'd1;
            pa_x2        <= q_x;
            pa_y2        <= q_y;
            pa_t2        <= q_t;
            pa_z2        <= 255'd1;
            pa_affine    <= 1'b1;
            pa_req_valid <= 1'b1;
            pa_res_ready <= 1'b0;
            state        <= ADD_REQ;
          end else begin
            // The sixteenth multiple is not stored; it becomes the next row's base.
            q_x <= acc_x;
            q_y <= acc_y;
            q_t <= acc_t;
            if (j == 6'd63) begin
              done_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              j     <= j + 6'd1;
              state <= WR_ZERO;
            end
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_precomp_table_gen.sv
// Directed bench for precomp_table_gen using a latency-4 additive mock adder with B = (1,1,1),
// so entry {j,i} is i*16^j modulo 2^255 in every coordinate.
module tb_precomp_table_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [254:0] bx, by, bt;
  logic         start_valid, start_ready, busy, done_valid, done_ready;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [255:0] wr_x, wr_y, wr_t;
  logic [254:0] pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2;
  logic         pa_affine, pa_req_valid, pa_req_ready, pa_req_busy, pa_res_valid, pa_res_ready;
  logic [254:0] pa_x3, pa_y3, pa_t3, pa_z3;

  precomp_table_gen dut (
    .clk(clk), .rst(rst), .bx(bx), .by(by), .bt(bt),
    .start_valid(start_valid), .start_ready(start_ready), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_t(wr_t),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_t1(pa_t1), .pa_z1(pa_z1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_t2(pa_t2), .pa_z2(pa_z2),
    .pa_affine(pa_affine), .pa_req_valid(pa_req_valid), .pa_req_ready(pa_req_ready),
    .pa_req_busy(pa_req_busy), .pa_res_valid(pa_res_valid), .pa_res_ready(pa_res_ready),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_t3(pa_t3), .pa_z3(pa_z3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mock adder: componentwise sum, optional stall before ready, result after 4 cycles.
  int stall_cycles = 0;
  int req_total = 0;
  int m_state, lat_cnt, stall_cnt;
  assign pa_z3 = 255'd1;

  always @(posedge clk) begin
    if (rst) begin
      m_state      <= 0;
      stall_cnt    <= 0;
      lat_cnt      <= 0;
      pa_req_ready <= 1'b0;
      pa_req_busy  <= 1'b0;
      pa_res_valid <= 1'b0;
    end else begin
      case (m_state)
        0: if (pa_req_valid) begin
          if (pa_req_ready) begin
            pa_req_ready <= 1'b0;
            pa_x3        <= pa_x1 + pa_x2;
            pa_y3        <= pa_y1 + pa_y2;
            pa_t3        <= pa_t1 + pa_t2;
            pa_req_busy  <= 1'b1;
            lat_cnt      <= 1;
            stall_cnt    <= 0;
            req_total    <= req_total + 1;
            m_state      <= 1;
          end else if (stall_cnt < stall_cycles) stall_cnt <= stall_cnt + 1;
          else pa_req_ready <= 1'b1;
        end
        1: if (lat_cnt == 4) begin
          pa_req_busy  <= 1'b0;
          pa_res_valid <= 1'b1;
          m_state      <= 2;
        end else lat_cnt <= lat_cnt + 1;
        2: if (pa_res_ready) begin
          pa_res_valid <= 1'b0;
          m_state      <= 0;
        end
        default: m_state <= 0;
      endcase
    end
  end

  // Write recorder plus request-side protocol monitor, sampled on the falling edge.
  logic [9:0]   rec_addr [1024];
  logic [255:0] rec_x [1024];
  logic [255:0] rec_y [1024];
  logic [255:0] rec_t [1024];
  int wr_total = 0, wr_base = 0, req_base = 0, mon_k;
  int aff_err = 0, stab_err = 0;
  logic prev_valid = 1'b0;
  logic [1529:0] saved_ops;

  always @(negedge clk) begin
    if (wr_en) begin
      mon_k = wr_total - wr_base;
      if (mon_k >= 0 && mon_k < 1024) begin
        rec_addr[mon_k] = wr_addr;
        rec_x[mon_k]    = wr_x;
        rec_y[mon_k]    = wr_y;
        rec_t[mon_k]    = wr_t;
      end
      wr_total++;
    end
    if (pa_req_valid) begin
      if (!pa_affine || pa_z1 != 255'd1 || pa_z2 != 255'd1) aff_err++;
      if (prev_valid && {pa_x1, pa_y1, pa_t1, pa_x2, pa_y2, pa_t2} != saved_ops) stab_err++;
      saved_ops = {pa_x1, pa_y1, pa_t1, pa_x2, pa_y2, pa_t2};
    end
    prev_valid = pa_req_valid;
  end

  function automatic logic [255:0] expVal(input int k, input int coord);
    int jj = k / 16;
    int ii = k % 16;
    logic [254:0] v;
    if (ii == 0) return (coord == 1) ? 256'd1 : 256'd0;
    v = 255'(ii) << (4 * jj);
    return {1'b0, v};
  endfunction

  task automatic checkTable(input string tag);
    int errs = 0;
    for (int k = 0; k < 1024; k++) begin
      if (rec_addr[k] !== 10'(k)) errs++;
      if (rec_x[k] !== expVal(k, 0)) errs++;
      if (rec_y[k] !== expVal(k, 1)) errs++;
      if (rec_t[k] !== expVal(k, 2)) errs++;
    end
    checkOutput({tag, " writes"}, wr_total - wr_base, 1024);
    checkOutput({tag, " requests"}, req_total - req_base, 960);
    checkOutput({tag, " table errors"}, errs, 0);
    checkOutput({tag, " affine errors"}, aff_err, 0);
  endtask

  task automatic applyStimulus(input string tag);
    @(negedge clk);
    wr_base     = wr_total;
    req_base    = req_total;
    aff_err     = 0;
    stab_err    = 0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput({tag, " start_ready"}, start_ready, 1);
    checkOutput({tag, " busy"}, busy, 1);
    @(negedge clk);
    checkOutput({tag, " first wr_en"}, wr_en, 1);
    checkOutput({tag, " first wr_addr"}, wr_addr, 0);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!done_valid && n < 25000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " done_valid"}, done_valid, 1);
    checkOutput({tag, " busy at done"}, busy, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " strobes"},
                {start_ready, busy, done_valid, wr_en, pa_req_valid, pa_res_ready, pa_affine}, 0);
    checkOutput({tag, " wr_addr"}, wr_addr, 0);
    checkOutput({tag, " wr_data"}, wr_x | wr_y | wr_t, 0);
  endtask

  initial begin
    int errs;
    int snap;
    int n;
    rst         = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    bx          = 255'd1;
    by          = 255'd1;
    bt          = 255'd1;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst = 1'b0;

    applyStimulus("run1");
    waitDone("run1");
    checkTable("run1");
    checkOutput("entry1 x equals B", rec_x[1], 256'd1);
    checkOutput("entry 0 y identity", rec_y[0], 256'd1);
    checkOutput("entry {1,3} x", rec_x[19], 256'h30);
    checkOutput("entry {63,8} wraps", rec_x[1016], 256'd0);
    checkOutput("entry {63,15} wraps", rec_t[1023], 256'h7 << 252);

    // Completion must stay pending while start_valid is pushed at it.
    stall_cycles = 5;
    start_valid  = 1'b1;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (!done_valid || busy || start_ready) errs++;
    end
    checkOutput("done held under start", errs, 0);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    checkOutput("done cleared", done_valid, 0);
    checkOutput("no start with done ack", start_ready, 0);
    wr_base  = wr_total;
    req_base = req_total;
    aff_err  = 0;
    stab_err = 0;
    @(negedge clk);
    checkOutput("start after idle", start_ready, 1);
    start_valid = 1'b0;
    waitDone("run2");
    checkTable("run2 stalled");
    checkOutput("run2 operand stability", stab_err, 0);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;

    // Interrupt a build with reset, then rebuild from scratch.
    stall_cycles = 0;
    applyStimulus("run3");
    n = 0;
    while ((wr_total - wr_base) < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run3 reached 100 writes", (wr_total - wr_base) >= 100, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("mid rst");
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    snap = wr_total;
    repeat (20) @(negedge clk);
    checkOutput("no writes after rst", wr_total - snap, 0);
    checkOutput("idle after rst", {busy, pa_req_valid}, 0);
    applyStimulus("run4");
    waitDone("run4");
    checkTable("run4 restart");
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
